// File: rtl/ppwm_pkg.sv
// Shared types and defaults for the PWM compare-value scheduler.
package ppwm_pkg;

  localparam int PPWM_NUM_CH_DFLT  = 4;
  localparam int PPWM_CW_DFLT      = 10;
  localparam int PPWM_TIMEOUT_DFLT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ppwm_sched_wdog.sv
// Per-channel WAIT-cycle watchdog; expire_o is combinational in the LIMIT-th counted cycle.
// Latency: 0 cycles from count to expire. No backpressure: clear_i always wins over counting.
// Only instantiated when PPWM_SCHED_TIMEOUT_EN is defined.
module ppwm_sched_wdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic start_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;

  assign w_expire = start_i && (r_cnt == CNT_W'(LIMIT - 1));
  assign expire_o = w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (start_i && !w_expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ppwm_sched.sv
// Shares one executor across NUM_CH PWM channels; collects a shadow bank and commits it on the next period start.
// Latency: ex_start_o one cycle after the accepted start; commit visible one cycle after period_start_i.
// Backpressure: WAIT holds until ex_done_i (or timeout with PPWM_SCHED_TIMEOUT_EN); starts while busy only flag overrun.
module ppwm_sched
  import ppwm_pkg::*;
#(
  parameter int  NUM_CH         = PPWM_NUM_CH_DFLT,
  parameter int  COUNTER_WIDTH  = PPWM_CW_DFLT,
  parameter int  TIMEOUT_CYCLES = PPWM_TIMEOUT_DFLT,
  localparam int CH_W           = ch_w(NUM_CH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable_i,
  input  logic                            period_start_i,
  input  logic                            clear_i,
  output logic                            ex_start_o,
  output logic [CH_W-1:0]                 ex_ch_o,
  input  logic                            ex_done_i,
  input  logic [COUNTER_WIDTH-1:0]        ex_value_i,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] cmp_values_o,
  output logic                            cmp_update_o,
  output logic                            busy_o,
  output logic                            overrun_o,
  output logic                            timeout_o
);

  localparam int CW = COUNTER_WIDTH;

  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("ppwm_sched: NUM_CH must be within 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ppwm_sched: TIMEOUT_CYCLES must be at least 1");
  end

  sched_state_e           r_state;
  sched_state_e           w_state_nxt;
  logic [CH_W-1:0]        r_ch;
  logic [CH_W-1:0]        w_ch_nxt;
  logic                   r_pending;
  logic [NUM_CH*CW-1:0]   r_shadow;
  logic [NUM_CH*CW-1:0]   r_active;
  logic                   r_cmp_update;
  logic                   r_overrun;
  logic                   w_expire;
  logic                   w_advance;
  logic                   w_capture;
  logic                   w_set_pending;
  logic                   w_commit;
  logic                   w_overrun_set;

`ifdef PPWM_SCHED_TIMEOUT_EN
  logic r_timeout;

  ppwm_sched_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (r_state == START),
    .start_i  (r_state == WAIT),
    .expire_o (w_expire)
  );

  // A done arriving in the expiry cycle is a real answer, so no timeout is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (w_expire && !ex_done_i) || (r_timeout && !clear_i);
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign w_capture     = (r_state == WAIT) && ex_done_i;
  assign w_advance     = ex_done_i || w_expire;
  assign w_commit      = period_start_i && r_pending;
  assign w_overrun_set = period_start_i && (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ch_nxt      = r_ch;
    w_set_pending = 1'b0;
    case (r_state)
      IDLE: begin
        if (period_start_i && enable_i) begin
          w_state_nxt = START;
          w_ch_nxt    = '0;
        end
      end
      START: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_advance) begin
          if (r_ch == CH_W'(NUM_CH - 1)) begin
            w_state_nxt   = IDLE;
            w_set_pending = 1'b1;
          end else begin
            w_state_nxt = START;
            w_ch_nxt    = r_ch + CH_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_capture && (r_ch == CH_W'(k))) begin
          r_shadow[k*CW +: CW] <= ex_value_i;
        end
      end
    end
  end

  // Completing a bank outranks a commit in the same cycle: the fresh bank must wait for the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= 1'b0;
      r_active     <= '0;
      r_cmp_update <= 1'b0;
    end else begin
      r_cmp_update <= w_commit;
      if (w_commit) begin
        r_active <= r_shadow;
      end
      if (w_set_pending) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun_set || (r_overrun && !clear_i);
    end
  end

  assign ex_start_o   = (r_state == START);
  assign ex_ch_o      = r_ch;
  assign busy_o       = (r_state != IDLE);
  assign cmp_values_o = r_active;
  assign cmp_update_o = r_cmp_update;
  assign overrun_o    = r_overrun;

endmodule

// File: doc/ppwm_sched.md
# ppwm_sched

Time-multiplexing scheduler that shares one instruction-execution unit between `NUM_CH` PWM channels. On each PWM period start it runs the executor once per channel in order and collects each channel's compare value into a shadow bank. At the following period start it commits the whole bank atomically to the per-channel PWM comparators. It sits between the global period-start strobe, the shared executor and the channel PWM generators.

## Interface
- `NUM_CH`, 4, number of PWM channels; legal range 2..16.
- `COUNTER_WIDTH`, 10, width of each compare value.
- `TIMEOUT_CYCLES`, 64, per-channel executor time budget in cycles (used only with the timeout feature).
- Derived: `CH_W` = max(1, $clog2(NUM_CH)).

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable_i` in 1: program memory is loaded; period starts are ignored while low.
- `period_start_i` in 1: one-cycle strobe marking the start of a PWM period.
- `clear_i` in 1: clears the sticky flags.
- `ex_start_o` out 1: one-cycle pulse that starts the executor.
- `ex_ch_o` out `CH_W`: channel currently being executed.
- `ex_done_i` in 1: executor result is valid.
- `ex_value_i` in `COUNTER_WIDTH`: executor result.
- `cmp_values_o` out `NUM_CH*COUNTER_WIDTH`: active compare values; channel k sits at bits [k*CW +: CW].
- `cmp_update_o` out 1: one-cycle pulse when the shadow bank is committed.
- `busy_o` out 1: a sequence is in progress (state != IDLE).
- `overrun_o` out 1: sticky; a period start arrived while busy.
- `timeout_o` out 1: sticky; a channel exceeded its time budget.

## Operation
- FSM states: IDLE, START, WAIT.
  - IDLE → START on `period_start_i & enable_i`; channel counter is set to 0.
  - START: `ex_start_o`=1 for this single cycle → WAIT.
  - WAIT, on `ex_done_i`: `shadow[ch]` <= `ex_value_i`.
    - If ch == NUM_CH-1: set `pending`, go to IDLE.
    - Otherwise: ch+1, go to START.
- `ex_done_i` is ignored in IDLE and START.
- Commit happens on `period_start_i` when `pending`=1: active <= shadow, `cmp_update_o` pulses, `pending` clears.
  - Commit is independent of `enable_i` and of FSM state.
- Overrun: `period_start_i` while state != IDLE sets `overrun_o`.
  - That start does not restart the sequence; the running sequence continues unchanged.
- Last `ex_done_i` in the same cycle as `period_start_i`:
  - The value is captured and `pending` is set.
  - Commit waits for the next period start.
  - `overrun_o` is set.
- Deasserting `enable_i` mid-sequence does not abort it.
- Sticky flags: `clear_i` clears them. If set and clear occur in the same cycle, set wins.
- `ex_ch_o` holds the current channel in START and WAIT, and holds its last value in IDLE.

## Timing
- Reset values:
  - state IDLE, ch 0, `pending` 0.
  - shadow and active banks all zero.
  - All outputs 0.
- `ex_start_o` is Moore-decoded: high in the cycle after the `period_start_i` edge.
- Earliest accepted `ex_done_i` is one cycle after `ex_start_o`.
- Per channel: 1 START cycle plus ≥1 WAIT cycle. Minimum sequence length is 2·NUM_CH cycles.
- `cmp_values_o` and `cmp_update_o` change in the cycle after the committing `period_start_i` edge.
- Reset mid-sequence returns to the reset state immediately; partially captured shadow values are discarded.

## Configuration
- `PPWM_SCHED_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs per channel.
  - On its TIMEOUT_CYCLES-th WAIT cycle without `ex_done_i`: `shadow[ch]` keeps its old value, `timeout_o` is set, and the FSM advances exactly as on done.
  - `ex_done_i` arriving in that same cycle wins, and no timeout is flagged.
- Undefined: WAIT has no time limit and `timeout_o` is tied to 0.

## Structure
- Package `ppwm_pkg` holds:
  - `sched_state_e` (IDLE/START/WAIT);
  - the `CH_W` helper function;
  - the default constants for `NUM_CH` and `TIMEOUT_CYCLES`.
- Optional sub-module `ppwm_sched_wdog` holds the timeout counter with start/clear/expire. It is instantiated only under `PPWM_SCHED_TIMEOUT_EN`.

## Test plan
- Commit path: reset; `enable_i`=1; period start; executor returns 5,6,7,8 two cycles after each start.
  - `ex_ch_o` steps 0..3.
  - Next period start → `cmp_update_o` pulses and channels read 5,6,7,8.
- Gating: `enable_i`=0 with period starts → no `ex_start_o`, `cmp_values_o` stays 0.
- Overrun: second period start while ch=1 is in WAIT → `overrun_o`=1.
  - The sequence finishes without restarting.
  - `clear_i` pulse → `overrun_o`=0.
- Coincidence: last done and period start in the same cycle.
  - No commit on that start.
  - Commit happens on the next start.
  - `overrun_o`=1.
- Timeout (macro on, TIMEOUT_CYCLES=8): channel 2 never answers.
  - After 8 WAIT cycles `timeout_o`=1 and the FSM moves to channel 3.
  - Channel 2 keeps its prior value after commit.
- Reset mid-sequence at ch=2 → all outputs 0 and FSM in IDLE next cycle; no commit on the following start.
